// File: rtl/mpu_drain.sv
// Output drain for the 8x8 systolic array: captures a full accumulator matrix,
// requantizes each element to int8 (round, shift, optional ReLU, saturate) and streams rows out.
module mpu_drain #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic signed [0:ROWS-1][0:COLS-1][ACC_W-1:0] c_in,
  input  logic [4:0]                                shift,
  input  logic                                      relu_en,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic signed [0:COLS-1][OUT_W-1:0]         out_data,
  output logic [2:0]                                out_row,
  output logic                                      out_last,
  output logic                                      busy,
  output logic                                      done
);

  localparam logic IDLE = 1'b0;
  localparam logic EMIT = 1'b1;

  localparam logic [4:0]             MAX_SHIFT = 5'(ACC_W - 1);
  localparam logic [2:0]             LAST_ROW  = 3'(ROWS - 1);
  localparam logic signed [ACC_W:0]  QMAX      = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0]  QMIN      = -QMAX - (ACC_W+1)'(1);

  logic                     state;
  logic signed [ACC_W-1:0]  mat_p0 [ROWS][COLS];
  logic [4:0]               shift_p0;
  logic                     relu_p0;

  logic                             accept;
  logic                             hs;
  logic [2:0]                       next_row;
  logic [4:0]                       q_shift;
  logic                             q_relu;
  logic signed [ACC_W-1:0]          src_row [COLS];
  logic signed [0:COLS-1][OUT_W-1:0] row_q;

  function automatic logic [4:0] clamp_shift(input logic [4:0] s);
    return (s > MAX_SHIFT) ? MAX_SHIFT : s;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] v);
    logic signed [ACC_W:0] r;
    if (v > QMAX)      r = QMAX;
    else if (v < QMIN) r = QMIN;
    else               r = v;
    return r[OUT_W-1:0];
  endfunction

  // Sign-extending by one bit leaves headroom so the rounding add cannot overflow.
  function automatic logic signed [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] x,
                                                      input logic [4:0] s,
                                                      input logic relu);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sh;
    ext = {x[ACC_W-1], x};
    if (s != 5'd0) rnd = ext + ((ACC_W+1)'(1) << (s - 5'd1));
    else           rnd = ext;
    sh = rnd >>> s;
    if (relu && sh < 0) sh = '0;
    return saturate(sh);
  endfunction

  always_comb begin
    accept   = (state == IDLE) && start;
    hs       = out_valid && out_ready;
    next_row = out_row + 3'd1;
    q_shift  = accept ? clamp_shift(shift) : shift_p0;
    q_relu   = accept ? relu_en : relu_p0;
    row_q    = '0;
    for (int j = 0; j < COLS; j++) begin
      src_row[j] = accept ? c_in[0][j] : mat_p0[next_row][j];
      row_q[j]   = requant(src_row[j], q_shift, q_relu);
    end
  end

  assign busy     = (state != IDLE);
  assign out_last = out_valid && (out_row == LAST_ROW);

  // Capture / emit stage: the row register is the only output pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      done      <= 1'b0;
      shift_p0  <= '0;
      relu_p0   <= 1'b0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          mat_p0[i][j] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < ROWS; i++)
              for (int j = 0; j < COLS; j++)
                mat_p0[i][j] <= c_in[i][j];
            shift_p0  <= clamp_shift(shift);
            relu_p0   <= relu_en;
            out_data  <= row_q;
            out_row   <= '0;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        default: begin
          if (hs) begin
            if (out_row == LAST_ROW) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              out_data <= row_q;
              out_row  <= next_row;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_drain.sv
// Directed bench for mpu_drain: identity, rounding, saturation/ReLU, backpressure,
// ignored start, back-to-back start and mid-transfer reset.
module tb_mpu_drain;

  logic                              clk;
  logic                              rst;
  logic                              start;
  logic signed [0:7][0:7][23:0]      c_in;
  logic [4:0]                        shift;
  logic                              relu_en;
  logic                              out_valid;
  logic                              out_ready;
  logic signed [0:7][7:0]            out_data;
  logic [2:0]                        out_row;
  logic                              out_last;
  logic                              busy;
  logic                              done;

  int errs   = 0;
  int checks = 0;
  int er [8];

  mpu_drain #(.ROWS(8), .COLS(8), .ACC_W(24), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .c_in(c_in), .shift(shift),
    .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_row(input string tag);
    for (int j = 0; j < 8; j++)
      chk($sformatf("%s[%0d]", tag, j), $signed(out_data[j]), er[j]);
  endtask

  task automatic load_identity();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        c_in[i][j] = 24'(8 * i + j);
  endtask

  task automatic do_start(input logic [4:0] s, input logic r);
    shift   = s;
    relu_en = r;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic drain_all();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && !done; n++) tick();
    chk("drain_done", done, 1);
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    int r;
    logic hs;
    logic mid_started;

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; c_in = '0; shift = '0; relu_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset / idle
    chk("rst_out_data", out_data, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_last", out_last, 0);
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("idle_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end

    // Identity pass with continuous ready
    load_identity();
    out_ready = 1'b1;
    do_start(5'd0, 1'b0);
    chk("id_busy", busy, 1);
    for (int k = 0; k < 8; k++) begin
      chk("id_valid", out_valid, 1);
      chk("id_row", out_row, k);
      chk("id_last", out_last, (k == 7) ? 1 : 0);
      chk("id_done_early", done, 0);
      for (int j = 0; j < 8; j++) er[j] = 8 * k + j;
      chk_row("id_data");
      tick();
    end
    chk("id_done", done, 1);
    chk("id_busy_end", busy, 0);
    chk("id_valid_end", out_valid, 0);
    out_ready = 1'b0;
    tick();
    chk("id_done_pulse", done, 0);

    // Rounding with shift=1
    c_in = '0;
    c_in[0][0] = 24'(5);  c_in[0][1] = 24'(-5); c_in[0][2] = 24'(6); c_in[0][3] = 24'(-6);
    c_in[0][4] = 24'(1);  c_in[0][5] = 24'(-1); c_in[0][6] = 24'(0); c_in[0][7] = 24'(3);
    do_start(5'd1, 1'b0);
    er = '{3, -2, 3, -3, 1, 0, 0, 2};
    chk_row("rnd_s1");
    drain_all();

    // Shift 31 clamps to 23
    c_in = '0;
    c_in[0][0] = 24'(8388607);
    c_in[0][1] = 24'(-8388608);
    do_start(5'd31, 1'b0);
    er = '{1, -1, 0, 0, 0, 0, 0, 0};
    chk_row("rnd_s31");
    drain_all();

    // Saturation without and with ReLU
    c_in = '0;
    c_in[0][0] = 24'(1000); c_in[0][1] = 24'(-1000); c_in[0][2] = 24'(127); c_in[0][3] = 24'(-128);
    c_in[0][4] = 24'(128);  c_in[0][5] = 24'(-129);  c_in[0][6] = 24'(0);   c_in[0][7] = 24'(-1);
    do_start(5'd0, 1'b0);
    er = '{127, -128, 127, -128, 127, -128, 0, -1};
    chk_row("sat");
    drain_all();
    do_start(5'd0, 1'b1);
    er = '{127, 0, 127, 0, 127, 0, 0, 0};
    chk_row("relu");
    drain_all();

    // Random backpressure plus a start mid-transfer that must be ignored
    load_identity();
    do_start(5'd0, 1'b0);
    r = 0;
    mid_started = 1'b0;
    for (int n = 0; n < 300 && r < 8; n++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_row", out_row, r);
      for (int j = 0; j < 8; j++) er[j] = 8 * r + j;
      chk_row("bp_data");
      out_ready = 1'($urandom_range(0, 1));
      if (r == 3 && !mid_started) begin
        mid_started = 1'b1;
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++)
            c_in[i][j] = 24'(99);
        start = 1'b1;
        shift = 5'd4;
      end
      hs = out_valid & out_ready;
      tick();
      start = 1'b0;
      if (hs) r++;
    end
    chk("bp_rows", r, 8);
    chk("bp_done", done, 1);

    // Start on the done cycle is accepted
    for (int j = 0; j < 8; j++) c_in[0][j] = 24'(10 * j - 30);
    out_ready = 1'b0;
    do_start(5'd0, 1'b0);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_row", out_row, 0);
    er = '{-30, -20, -10, 0, 10, 20, 30, 40};
    chk_row("b2b_data");
    drain_all();

    // Reset after three accepted rows
    load_identity();
    out_ready = 1'b1;
    do_start(5'd0, 1'b0);
    repeat (3) tick();
    chk("mr_row_before", out_row, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    chk("mr_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_row", out_row, 0);
    tick();
    chk("mr_done_after", done, 0);
    for (int j = 0; j < 8; j++) c_in[0][j] = 24'(7 * j - 20);
    do_start(5'd0, 1'b0);
    er = '{-20, -13, -6, 1, 8, 15, 22, 29};
    chk_row("mr_fresh");
    chk("mr_fresh_valid", out_valid, 1);
    drain_all();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mpu_drain.md
# mpu_drain

Output drain and requantizer for the int8 matrix unit. It sits directly downstream of the 8x8 systolic array. When the controller signals that a result is ready, the block captures the array's full 8x8 matrix of signed 24-bit accumulators. It then rescales each element to signed int8 (rounding right shift, optional ReLU, saturation) and streams the matrix out one row per valid/ready handshake.

## Interface
Parameters:
- ROWS, 8, result rows (row index width is fixed at 3 bits; only 8 is supported)
- COLS, 8, result columns
- ACC_W, 24, accumulator width of c_in
- OUT_W, 8, output element width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: c_in holds a finished result
- c_in  in  signed [ACC_W-1:0] [0:ROWS-1][0:COLS-1]  systolic array result matrix
- shift  in  5  right-shift amount, sampled on accepted start
- relu_en  in  1  clamp negatives to 0, sampled on accepted start
- out_valid  out  1  out_data holds a valid row
- out_ready  in  1  downstream accepts the row this cycle
- out_data  out  signed [OUT_W-1:0] [0:COLS-1]  quantized row
- out_row  out  3  index of the row on out_data
- out_last  out  1  high with out_valid when out_row == ROWS-1
- busy  out  1  high while a matrix is held (state != IDLE)
- done  out  1  one-cycle pulse after the last row is accepted

## Operation
- States: IDLE, EMIT.
- **IDLE**
  - start=1: latch all of c_in into an internal buffer.
  - Latch shift into an effective shift. Values above 23 saturate to 23.
  - Latch relu_en.
  - Load row 0, quantized, into the out_data register.
  - out_row <= 0; out_valid <= 1; go to EMIT.
- **EMIT**
  - Handshake = out_valid & out_ready.
  - No handshake: out_data, out_row and out_last hold stable.
  - Handshake with out_row < 7: load the next row into out_data and increment out_row in the same cycle. There is no bubble between rows.
  - Handshake with out_row == 7: out_valid <= 0; done <= 1 for one cycle; go to IDLE.
- start in EMIT is ignored. The buffer is not overwritten and no error is flagged.
- Quantization, per element x (signed 24-bit), with s = effective shift:
  - Sign-extend to 25 bits.
  - If s > 0, add 2^(s-1) (round half toward +infinity).
  - Arithmetic right shift by s.
  - If relu_en, negative results become 0.
  - Saturate to [-128, 127].
  - With s == 0 the element passes unrounded, then saturates.
- c_in is read only in the start cycle. Later changes to c_in do not affect the rows being emitted.

## Timing
- Reset values: out_valid=0, out_data all 0, out_row=0, out_last=0, busy=0, done=0, state=IDLE, buffer cleared.
- rst mid-transfer aborts immediately to IDLE with reset values. done is not pulsed.
- Start accepted at edge T:
  - out_valid=1, row 0, busy=1, visible after T.
  - With out_ready held high, rows 0..7 handshake on edges T+1..T+8.
  - done=1 and busy=0 after edge T+8.
- Minimum spacing between accepted starts is 9 cycles with continuous ready.
- start asserted in the same cycle as done is high: state is IDLE, so the start is accepted. Back-to-back matrices are therefore sustained with 1 idle cycle between them.
- out_ready low stalls indefinitely with no loss. Output is not combinationally dependent on out_ready except for state advance.
- out_last = out_valid & (out_row == 7).

## Test plan
- **Reset/idle.** Hold rst 3 cycles, then start=0 for 10 cycles -> all outputs 0, done never pulses.
- **Identity pass.** c_in[i][j] = 8*i+j, shift=0, relu_en=0, ready=1 -> rows 0..7 on consecutive cycles, row k element j = 8k+j. out_last only on row 7; done one cycle later.
- **Rounding and shift.** c_in row 0 = {5, -5, 6, -6, 1, -1, 0, 3}, shift=1 -> {3, -2, 3, -3, 1, 0, 0, 2}. With shift=31 (saturates to 23): 8388607 -> 1, -8388608 -> -1.
- **Saturation/ReLU.** Row 0 = {1000, -1000, 127, -128, 128, -129, 0, -1}, shift=0:
  - relu_en=0 -> {127, -128, 127, -128, 127, -128, 0, -1}.
  - relu_en=1 -> {127, 0, 127, 0, 127, 0, 0, 0}.
- **Backpressure and ignored start.**
  - Random out_ready at 50% -> data held stable while stalled, all 8 rows emitted in order.
  - A start mid-transfer with different c_in -> emitted data is unchanged.
  - A start on the done cycle -> second matrix begins, row 0 valid on the next cycle.
- **Reset mid-operation.** Assert rst after 3 rows are accepted -> next cycle out_valid=0, busy=0, no done pulse. A fresh start then emits row 0 of the new matrix.
